// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_pkg.sv
// Shared definitions for the cell BIST sequencers: state encoding,
// vector width and the aoi21 golden model.
package gf180mcu_fd_sc_mcu9t5v0__bist_pkg;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } bist_state_t;

  // Expected ZN for vector {A1,A2,B}: ZN = !((A1 & A2) | B)
  function automatic logic aoi21_golden(input logic [VEC_W-1:0] vec);
    return ~((vec[2] & vec[1]) | vec[0]);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_if.sv
// Control/status bus of the aoi21 BIST sequencer. The master issues
// START/ABORT levels; the sequencer (slave) returns run status and results.
interface gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_if
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
  parameter int ERR_W = 8
);
  logic             START;
  logic             ABORT;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [ERR_W-1:0] ERR_CNT;
  logic             FAIL_VALID;
  logic [VEC_W-1:0] FAIL_VEC;

  modport master (
    output START, ABORT,
    input  BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC
  );

  modport slave (
    input  START, ABORT,
    output BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_cell.sv
// Behavioural aoi21 cell: ZN = !((A1 & A2) | B).
module gf180mcu_fd_sc_mcu9t5v0__aoi21 (
  input  logic A1,
  input  logic A2,
  input  logic B,
  output logic ZN
);
  assign ZN = ~((A1 & A2) | B);
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_top.sv
// Characterisation wrapper: one BIST sequencer driving one aoi21 cell,
// with the cell output looped back. Cell pins are exposed for observation.
module gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_top #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic CLK,
  input  logic RST,
  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_if.slave bus,
  output logic A1,
  output logic A2,
  output logic B,
  output logic ZN
);

  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(
    .SETTLE (SETTLE),
    .PASSES (PASSES),
    .ERR_W  (ERR_W)
  ) u_seq (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .A1  (A1),
    .A2  (A2),
    .B   (B),
    .ZN  (ZN)
  );

  gf180mcu_fd_sc_mcu9t5v0__aoi21 u_cell (
    .A1 (A1),
    .A2 (A2),
    .B  (B),
    .ZN (ZN)
  );

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv
// BIST sequencer for the aoi21 cell. Sweeps {A1,A2,B} through 0..7 for
// PASSES sweeps, holds each vector SETTLE cycles plus one sample cycle,
// compares ZN with the golden model and records mismatch statistics.
module gf180mcu_fd_sc_mcu9t5v0__aoi21_bist
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic CLK,
  input  logic RST,
  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_if.slave bus,
  output logic A1,
  output logic A2,
  output logic B,
  input  logic ZN
);

  localparam int PW = $clog2(PASSES) + 1;
  localparam int SW = $clog2(SETTLE) + 1;
  localparam logic [PW-1:0]    PCNT_LAST = PW'(PASSES - 1);
  localparam logic [SW-1:0]    SCNT_INIT = SW'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  bist_state_t      state;
  logic [VEC_W-1:0] vec;
  logic [PW-1:0]    pcnt;
  logic [SW-1:0]    scnt;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [VEC_W-1:0] fail_vec;
  logic             busy;
  logic             done;
  logic             pass;

  logic             mismatch;
  logic [ERR_W-1:0] err_inc;

  // ZN is only meaningful in SAMPLE; the counter saturates at its maximum
  assign mismatch = (ZN != aoi21_golden(vec));
  assign err_inc  = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;

  // The vector register is the cell drive, so the cell inputs are registered
  assign {A1, A2, B} = vec;

  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.PASS       = pass;
  assign bus.ERR_CNT    = err_cnt;
  assign bus.FAIL_VALID = fail_valid;
  assign bus.FAIL_VEC   = fail_vec;

  // Sequencer FSM with registered status outputs; RST beats ABORT beats START
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      vec        <= '0;
      pcnt       <= '0;
      scnt       <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (bus.ABORT) begin
      // results are kept for debug; only the sequencing is dropped
      state <= ST_IDLE;
      vec   <= '0;
      pcnt  <= '0;
      scnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            state      <= ST_SETTLE;
            vec        <= '0;
            pcnt       <= '0;
            scnt       <= SCNT_INIT;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (scnt == '0) state <= ST_SAMPLE;
          else            scnt  <= scnt - 1'b1;
        end
        ST_SAMPLE: begin
          err_cnt <= err_inc;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec;
          end
          if (vec != VEC_LAST) begin
            vec   <= vec + 1'b1;
            scnt  <= SCNT_INIT;
            state <= ST_SETTLE;
          end else if (pcnt != PCNT_LAST) begin
            vec   <= '0;
            pcnt  <= pcnt + 1'b1;
            scnt  <= SCNT_INIT;
            state <= ST_SETTLE;
          end else begin
            // vector 7 stays driven while DONE is held
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_inc == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv
// Directed bench for the aoi21 BIST sequencer and its wrapper.
//   u0 : defaults, ZN from a bench mux (functional cell or stuck at 1)
//   u1 : PASSES=3, SETTLE=1, ZN stuck at 0
//   u2 : ERR_W=2, PASSES=4, ZN inverted
//   uw : wrapper with a real cell looped back
module tb_gf180mcu_fd_sc_mcu9t5v0__aoi21_bist;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_if #(.ERR_W(8)) bi0 ();
  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_if #(.ERR_W(8)) bi1 ();
  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_if #(.ERR_W(2)) bi2 ();
  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_if #(.ERR_W(8)) biw ();

  logic a1_0, a2_0, b_0, zn0;
  logic a1_1, a2_1, b_1;
  logic a1_2, a2_2, b_2;
  logic uw_a1, uw_a2, uw_b, uw_zn;
  logic zmode; // 0: functional cell, 1: ZN stuck at 1

  always_comb begin
    zn0 = 1'b1;
    if (!zmode) zn0 = ~((a1_0 & a2_0) | b_0);
  end

  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist u0 (
    .CLK(clk), .RST(rst), .bus(bi0),
    .A1(a1_0), .A2(a2_0), .B(b_0), .ZN(zn0)
  );

  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(.SETTLE(1), .PASSES(3)) u1 (
    .CLK(clk), .RST(rst), .bus(bi1),
    .A1(a1_1), .A2(a2_1), .B(b_1), .ZN(1'b0)
  );

  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(.ERR_W(2), .PASSES(4)) u2 (
    .CLK(clk), .RST(rst), .bus(bi2),
    .A1(a1_2), .A2(a2_2), .B(b_2), .ZN((a1_2 & a2_2) | b_2)
  );

  gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_top uw (
    .CLK(clk), .RST(rst), .bus(biw),
    .A1(uw_a1), .A2(uw_a2), .B(uw_b), .ZN(uw_zn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // outputs are sampled and inputs changed on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_u0_reset(input string tag);
    chk({tag, "_vec"},   {a1_0, a2_0, b_0}, 0);
    chk({tag, "_busy"},  bi0.BUSY, 0);
    chk({tag, "_done"},  bi0.DONE, 0);
    chk({tag, "_pass"},  bi0.PASS, 0);
    chk({tag, "_err"},   bi0.ERR_CNT, 0);
    chk({tag, "_fv"},    bi0.FAIL_VALID, 0);
    chk({tag, "_fvec"},  bi0.FAIL_VEC, 0);
  endtask

  initial begin
    rst = 1'b1;
    zmode = 1'b1;
    bi0.START = 0; bi0.ABORT = 0;
    bi1.START = 0; bi1.ABORT = 0;
    bi2.START = 0; bi2.ABORT = 0;
    biw.START = 0; biw.ABORT = 0;
    step(3);
    rst = 1'b0;
    chk_u0_reset("rst");
    chk("rst_u2_err", bi2.ERR_CNT, 0);
    step(1);

    // all four runs launched on the same edge
    bi0.START = 1; bi1.START = 1; bi2.START = 1; biw.START = 1;
    for (int c = 1; c <= 100; c++) begin
      step(1);
      if (c == 1) begin
        bi0.START = 0; bi1.START = 0; bi2.START = 0; biw.START = 0;
        chk("uw_zn_vec0", uw_zn, 1);
      end
      if (c <= 24) chk("uw_vec", {uw_a1, uw_a2, uw_b}, (c - 1) / 3);
      chk("uw_done", biw.DONE, (c >= 25) ? 1 : 0);
      chk("uw_busy", biw.BUSY, (c < 25) ? 1 : 0);
      chk("u1_done", bi1.DONE, (c >= 49) ? 1 : 0);
      chk("u2_done", bi2.DONE, (c >= 97) ? 1 : 0);
      if (c == 7)  chk("u2_err_c7", bi2.ERR_CNT, 2);
      if (c == 40) chk("u2_err_sat", bi2.ERR_CNT, 3);
    end

    chk("uw_pass", biw.PASS, 1);
    chk("uw_err",  biw.ERR_CNT, 0);
    chk("uw_fv",   biw.FAIL_VALID, 0);
    chk("uw_vec7", {uw_a1, uw_a2, uw_b}, 7);

    chk("u0_err",  bi0.ERR_CNT, 5);
    chk("u0_fvec", bi0.FAIL_VEC, 1);
    chk("u0_fv",   bi0.FAIL_VALID, 1);
    chk("u0_pass", bi0.PASS, 0);
    chk("u0_done", bi0.DONE, 1);

    chk("u1_err",  bi1.ERR_CNT, 9);
    chk("u1_fvec", bi1.FAIL_VEC, 0);
    chk("u1_fv",   bi1.FAIL_VALID, 1);
    chk("u1_pass", bi1.PASS, 0);

    chk("u2_err_end", bi2.ERR_CNT, 3);
    chk("u2_fvec",    bi2.FAIL_VEC, 0);

    // restart u0 from DONE with ZN stuck at 1, then abort during vector 5
    bi0.START = 1;
    step(1);
    bi0.START = 0;
    chk("rs_err",  bi0.ERR_CNT, 0);
    chk("rs_fv",   bi0.FAIL_VALID, 0);
    chk("rs_busy", bi0.BUSY, 1);
    chk("rs_done", bi0.DONE, 0);
    step(15);
    chk("ab_vec5", {a1_0, a2_0, b_0}, 5);
    chk("ab_err_pre", bi0.ERR_CNT, 2);
    bi0.ABORT = 1;
    step(1);
    chk("ab_vec",  {a1_0, a2_0, b_0}, 0);
    chk("ab_busy", bi0.BUSY, 0);
    chk("ab_done", bi0.DONE, 0);
    chk("ab_err",  bi0.ERR_CNT, 2);
    chk("ab_fv",   bi0.FAIL_VALID, 1);
    chk("ab_fvec", bi0.FAIL_VEC, 1);
    bi0.START = 1;
    step(1);
    chk("ab_st_busy", bi0.BUSY, 0);
    chk("ab_st_vec",  {a1_0, a2_0, b_0}, 0);
    chk("ab_st_err",  bi0.ERR_CNT, 2);
    bi0.START = 0; bi0.ABORT = 0;
    step(2);
    chk("ab_idle_busy", bi0.BUSY, 0);

    // reset during vector 3 with a mismatch already counted
    bi0.START = 1;
    step(1);
    bi0.START = 0;
    step(9);
    chk("rr_vec3", {a1_0, a2_0, b_0}, 3);
    chk("rr_err_pre", bi0.ERR_CNT, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_u0_reset("mrst");

    // clean functional run; a START while busy must not restart it
    zmode = 1'b0;
    step(1);
    bi0.START = 1;
    step(1);
    bi0.START = 0;
    step(4);
    bi0.START = 1;
    step(1);
    bi0.START = 0;
    chk("cl_busy", bi0.BUSY, 1);
    chk("cl_vec1", {a1_0, a2_0, b_0}, 1);
    step(18);
    chk("cl_done24", bi0.DONE, 0);
    step(1);
    chk("cl_done25", bi0.DONE, 1);
    chk("cl_busy25", bi0.BUSY, 0);
    chk("cl_pass", bi0.PASS, 1);
    chk("cl_err",  bi0.ERR_CNT, 0);
    chk("cl_fv",   bi0.FAIL_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.md
# gf180mcu_fd_sc_mcu9t5v0__aoi21_bist

Built-in self-test sequencer for the aoi21 cell (ZN = !((A1 & A2) | B)). It drives the cell inputs through all 8 input combinations for a configurable number of sweeps and waits a programmable settle time per vector. It compares ZN against a golden model, counts mismatches and records the first failing vector. It sits beside a cell instance in characterisation and silicon-debug wrappers, and is the only driver of that instance's inputs.

## Interface
- SETTLE, default 2: cycles each vector is held before ZN is sampled; legal range ≥1.
- PASSES, default 1: number of full 8-vector sweeps per run; legal range ≥1.
- ERR_W, default 8: width of the mismatch counter.
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  level; sampled only in IDLE and DONE.
- ABORT  input  1  level; returns the block to IDLE from any state.
- A1, A2, B  output  1 each  registered drives to the cell under test.
- ZN  input  1  cell output; sampled directly in the CLK domain.
- BUSY  output  1  high in SETTLE and SAMPLE.
- DONE  output  1  high in DONE.
- PASS  output  1  DONE & (ERR_CNT == 0).
- ERR_CNT  output  ERR_W  mismatch count; saturates at 2^ERR_W−1.
- FAIL_VALID  output  1  set on the first mismatch of a run.
- FAIL_VEC  output  3  {A1,A2,B} of the first mismatch; valid when FAIL_VALID is high.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Vector index vec[2:0] maps to {A1,A2,B} = vec. Sweep order is 0→7. Pass counter pcnt runs 0..PASSES−1.
- IDLE: drives vector 0.
  - START → SETTLE with vec=0, pcnt=0, scnt=SETTLE−1.
  - Entering SETTLE clears ERR_CNT, FAIL_VALID and FAIL_VEC.
- SETTLE: decrement scnt each cycle. At scnt==0 → SAMPLE.
- SAMPLE (1 cycle): compare ZN with golden(vec).
  - On mismatch: ERR_CNT+1 (saturating). If FAIL_VALID is 0, load FAIL_VEC=vec and set FAIL_VALID.
  - At the same edge:
    - if vec<7: vec+1 → SETTLE.
    - else if pcnt<PASSES−1: vec wraps to 0, pcnt+1 → SETTLE.
    - else → DONE.
- DONE: outputs hold, vector 7 stays driven, results stay stable. START restarts exactly as from IDLE.
- START while BUSY is ignored.
- ABORT at any state: next edge → IDLE, vector 0 driven. ERR_CNT, FAIL_VALID and FAIL_VEC hold their last values for debug. ABORT beats START in the same cycle.
- RST overrides everything, including ABORT.
- Golden values:
  - ZN = 1 for vec 0, 2, 4.
  - ZN = 0 for vec 1, 3, 5, 6, 7.

## Timing
- Reset values: A1=A2=B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VALID=0, FAIL_VEC=0. State = IDLE.
- A new vector appears at the edge that enters SETTLE. ZN is sampled at the edge ending SAMPLE, i.e. SETTLE+1 cycles after the vector changes.
- Per vector: SETTLE+1 cycles.
- Run length: START edge to DONE=1 takes PASSES·8·(SETTLE+1) cycles. With defaults this is 24.
- BUSY rises one cycle after START is sampled. BUSY falls on the same edge DONE rises.
- RST asserted mid-run: all outputs return to reset values at the next edge; no partial results are retained.
- ERR_CNT stays at its maximum value once saturated. FAIL_VEC is never overwritten within a run.

## Structure
- Shared package gf180mcu_fd_sc_mcu9t5v0__bist_pkg holds:
  - the state enum;
  - VEC_W=3;
  - the aoi21_golden(vec) function, so other cell BISTs can reuse the package pattern.
- Pass counter width is $clog2(PASSES)+1; settle counter width is $clog2(SETTLE)+1.
- No sub-module inside the sequencer.
- Wrapper gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_top instantiates the sequencer and one aoi21 cell, ZN looped back.

## Test plan
- Defaults, functional cell via the wrapper, START for 1 cycle:
  - vectors 0..7 each held 3 cycles;
  - DONE at cycle 24;
  - PASS=1, ERR_CNT=0, FAIL_VALID=0.
- ZN forced to a constant 1:
  - ERR_CNT=5, FAIL_VEC=3'b001, FAIL_VALID=1, PASS=0.
- PASSES=3, SETTLE=1, ZN stuck at 0:
  - run length is 48 cycles;
  - ERR_CNT=9 (3 errors per sweep on vec 0, 2, 4);
  - FAIL_VEC=0.
- ERR_W=2, PASSES=4, ZN inverted:
  - ERR_CNT saturates at 3 and stays at 3;
  - FAIL_VEC=0.
- ABORT asserted during vector 5:
  - next edge: IDLE, A1=A2=B=0, BUSY=0;
  - errors accumulated so far are retained;
  - START with ABORT both high in IDLE: stays in IDLE.
- RST pulse during vector 3 with mismatches present:
  - all outputs reach their reset values at the next edge;
  - a following START gives a clean 24-cycle run.
